acc_traffic_driver: RTL and testbench
=====================================

Name: acc_traffic_driver

Overview:
- Self-checking stimulus source and sink for one accelerator slot in the fifo_controller acc_unit.
- Drives bursts of patterned words into the accelerator's consumer port. Drains and checks the accelerator's producer port.
- Counts bursts, errors and round-trip latency.
- Used in tile-level bring-up to exercise accelerator slots without the cohort FIFO path.

Parameters:
- MAX_BURSTS, 16'hFFFF, upper clamp applied to num_bursts.
- LAT_W, 16, width of the latency measurement counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  level-sensitive go; rising edge seen in IDLE or DONE starts a run
- num_bursts  in  16  bursts per run
- serialization_ratio  in  16  words sent per burst
- deserialization_ratio  in  16  words received per burst
- seed  in  32  first pattern word of the run
- ready_gap  in  4  idle cycles inserted before each producer-side ready
- consumer_data  decoupled_vr_if.master  data_t  words into the accelerator consumer port
- producer_data  decoupled_vr_if.slave  data_t  words from the accelerator producer port
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- error  out  1  sticky: mismatch seen or config rejected
- cfg_err  out  1  sticky: last start rejected for a zero ratio
- err_count  out  16  saturating mismatch count
- burst_count  out  16  completed bursts in the current run
- last_latency  out  LAT_W  cycles from last send handshake of a burst to first receive handshake of that burst (saturating)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, all outputs 0, consumer_data.valid=0, consumer_data.data=0, producer_data.ready=0.
- Reset asserted mid-run drops valid and ready in the same cycle, without waiting for clk. No handshake is completed.
- Config sampling: all config inputs are sampled on the start edge and held internally for the whole run.
- Pattern: a 32-bit word_id register loads seed at start and increments after every consumer handshake. Send data is word_id replicated across the data_t width.
- States: IDLE, SEND, RECV, DONE.
- IDLE/DONE on start rising edge:
  - If either ratio is 0: go to DONE, set cfg_err=1 and error=1.
  - Else if num_bursts is 0: go to DONE with no error.
  - Else: clear err_count, burst_count, error and cfg_err, then go to SEND.
- SEND:
  - consumer_data.valid=1 every cycle; data holds stable until the handshake.
  - A handshake is valid&ready; each one increments the send counter.
  - On handshake number serialization_ratio: latch expected = that word, clear the latency counter, go to RECV next cycle.
- RECV, ready generation:
  - ready=1 only when the gap counter is 0.
  - The gap counter reloads to ready_gap at RECV entry and after each handshake, and decrements otherwise. ready_gap=0 means ready is held high.
- RECV, checking:
  - The latency counter increments every RECV cycle until the first handshake, then its value is captured into last_latency.
  - Each handshake compares the full data_t against expected. On mismatch, err_count increments (saturating at 16'hFFFF) and error is set.
  - On handshake number deserialization_ratio, burst_count increments. Next state is DONE if burst_count equals min(num_bursts, MAX_BURSTS), else SEND; the send counter resets.
- Status outputs: busy=1 in SEND and RECV. done=1 in DONE.
- start held high does not retrigger a run; only a new rising edge does. start edges in SEND or RECV are ignored.
- Counter widths: 16-bit send and receive counters compare for equality against the ratio; they never wrap within a burst.
- Latency saturates at all ones.
- No valid and ready combinational path: both are registered state decodes.

Test Plan:
- seed=32'h100, ser=4, deser=2, bursts=1, DUT echo model returns the last word twice:
  - 4 sends: 0x100..0x103.
  - 2 receives checked against 0x103.
  - Outputs: done=1, error=0, burst_count=1.
- Same config, model returns 0x102 on the second word:
  - err_count=1, error=1, done=1.
- ser=0, start:
  - DONE next cycle, cfg_err=1, error=1, valid never asserted.
- bursts=3, ser=1, deser=1, ready_gap=3, model waits 5 cycles before valid:
  - ready rises 3 cycles after RECV entry each burst.
  - last_latency=5.
  - burst_count=3, pattern words 0x..,+1,+2.
- Async rst_n pulse mid-SEND while the consumer is stalled:
  - valid drops immediately; all counters read 0.
  - A fresh start runs cleanly from seed.
- start held high after DONE:
  - No new run begins.
  - Toggle start low then high: a new run begins and err_count is cleared.

Source files
------------

// File: rtl/acc_traffic_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : decoupled_vr_if
// Purpose  : Valid/ready word channel used on both sides of an accelerator slot.
// Revision : 1.0
// ============================================================================
interface decoupled_vr_if #(
  parameter int DATA_W = 64
);
  typedef logic [DATA_W-1:0] data_t;

  logic  valid;
  logic  ready;
  data_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/acc_traffic_driver.sv
`default_nettype none
// ============================================================================
// Module   : acc_traffic_driver
// Purpose  : Patterned burst source / checked sink for one accelerator slot.
// Revision : 1.0
// ============================================================================
module acc_traffic_driver #(
  parameter logic [15:0] MAX_BURSTS = 16'hFFFF,
  parameter int          LAT_W      = 16,
  parameter int          DATA_W     = 64
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  input  wire logic [15:0]        num_bursts,
  input  wire logic [15:0]        serialization_ratio,
  input  wire logic [15:0]        deserialization_ratio,
  input  wire logic [31:0]        seed,
  input  wire logic [3:0]         ready_gap,
  decoupled_vr_if.master          consumer_data,
  decoupled_vr_if.slave           producer_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cfg_err,
  output logic [15:0]             err_count,
  output logic [15:0]             burst_count,
  output logic [LAT_W-1:0]        last_latency
);

  localparam int REPL = DATA_W / 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                start_prev_q;
  logic [15:0]         ser_q, ser_d, deser_q, deser_d, bursts_q, bursts_d;
  logic [3:0]          gap_cfg_q, gap_cfg_d, gap_q, gap_d;
  logic [31:0]         word_id_q, word_id_d;
  logic [15:0]         send_cnt_q, send_cnt_d, recv_cnt_q, recv_cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d, last_lat_q, last_lat_d;
  logic [DATA_W-1:0]   expected_q, expected_d;
  logic                valid_q, valid_d, ready_q, ready_d;
  logic [15:0]         err_cnt_q, err_cnt_d, burst_cnt_q, burst_cnt_d;
  logic                error_q, error_d, cfg_err_q, cfg_err_d;

  logic                start_rise;
  logic                send_hs;
  logic                recv_hs;
  logic [DATA_W-1:0]   send_word;
  logic [15:0]         bursts_clamped;
  logic                ratio_zero;

  assign start_rise     = start & ~start_prev_q;
  assign send_hs        = valid_q & consumer_data.ready;
  assign recv_hs        = ready_q & producer_data.valid;
  assign send_word      = {REPL{word_id_q}};
  assign bursts_clamped = (num_bursts > MAX_BURSTS) ? MAX_BURSTS : num_bursts;
  assign ratio_zero     = (serialization_ratio == 16'd0) || (deserialization_ratio == 16'd0);

  always_comb begin
    state_d     = state_q;
    ser_d       = ser_q;
    deser_d     = deser_q;
    bursts_d    = bursts_q;
    gap_cfg_d   = gap_cfg_q;
    gap_d       = gap_q;
    word_id_d   = word_id_q;
    send_cnt_d  = send_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    lat_d       = lat_q;
    last_lat_d  = last_lat_q;
    expected_d  = expected_q;
    err_cnt_d   = err_cnt_q;
    burst_cnt_d = burst_cnt_q;
    error_d     = error_q;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          ser_d     = serialization_ratio;
          deser_d   = deserialization_ratio;
          bursts_d  = bursts_clamped;
          gap_cfg_d = ready_gap;
          word_id_d = seed;
          if (ratio_zero) begin
            state_d   = DONE;
            cfg_err_d = 1'b1;
            error_d   = 1'b1;
          end else if (bursts_clamped == 16'd0) begin
            state_d = DONE;
          end else begin
            err_cnt_d   = 16'd0;
            burst_cnt_d = 16'd0;
            error_d     = 1'b0;
            cfg_err_d   = 1'b0;
            send_cnt_d  = 16'd0;
            recv_cnt_d  = 16'd0;
            state_d     = SEND;
          end
        end
      end
      SEND: begin
        if (send_hs) begin
          word_id_d  = word_id_q + 32'd1;
          send_cnt_d = send_cnt_q + 16'd1;
          if (send_cnt_d == ser_q) begin
            expected_d = send_word;
            lat_d      = '0;
            gap_d      = gap_cfg_q;
            recv_cnt_d = 16'd0;
            state_d    = RECV;
          end
        end
      end
      RECV: begin
        if (recv_hs) begin
          gap_d = gap_cfg_q;
          if (recv_cnt_q == 16'd0) begin
            last_lat_d = lat_q;
          end
          if (producer_data.data != expected_q) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          recv_cnt_d = recv_cnt_q + 16'd1;
          if (recv_cnt_d == deser_q) begin
            burst_cnt_d = burst_cnt_q + 16'd1;
            send_cnt_d  = 16'd0;
            recv_cnt_d  = 16'd0;
            state_d     = (burst_cnt_d == bursts_q) ? DONE : SEND;
          end
        end else if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end
        // Latency only runs until the first receive handshake of the burst.
        if ((recv_cnt_q == 16'd0) && !recv_hs && (lat_q != {LAT_W{1'b1}})) begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // valid/ready are registered decodes of the next state, so no input reaches them combinationally.
  assign valid_d = (state_d == SEND);
  assign ready_d = (state_d == RECV) && (gap_d == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      ser_q        <= 16'd0;
      deser_q      <= 16'd0;
      bursts_q     <= 16'd0;
      gap_cfg_q    <= 4'd0;
      gap_q        <= 4'd0;
      word_id_q    <= 32'd0;
      send_cnt_q   <= 16'd0;
      recv_cnt_q   <= 16'd0;
      lat_q        <= '0;
      last_lat_q   <= '0;
      expected_q   <= '0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
      err_cnt_q    <= 16'd0;
      burst_cnt_q  <= 16'd0;
      error_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      ser_q        <= ser_d;
      deser_q      <= deser_d;
      bursts_q     <= bursts_d;
      gap_cfg_q    <= gap_cfg_d;
      gap_q        <= gap_d;
      word_id_q    <= word_id_d;
      send_cnt_q   <= send_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      lat_q        <= lat_d;
      last_lat_q   <= last_lat_d;
      expected_q   <= expected_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      err_cnt_q    <= err_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      error_q      <= error_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign consumer_data.valid = valid_q;
  assign consumer_data.data  = send_word;
  assign producer_data.ready = ready_q;

  assign busy         = (state_q == SEND) || (state_q == RECV);
  assign done         = (state_q == DONE);
  assign error        = error_q;
  assign cfg_err      = cfg_err_q;
  assign err_count    = err_cnt_q;
  assign burst_count  = burst_cnt_q;
  assign last_latency = last_lat_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_traffic_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_traffic_driver
// Purpose  : Directed vector bench with an echo model for acc_traffic_driver.
// Revision : 1.0
// ============================================================================
module tb_acc_traffic_driver;

  typedef struct {
    logic [31:0] seed;
    logic [15:0] ser;
    logic [15:0] deser;
    logic [15:0] bursts;
    logic [3:0]  gap;
    int          wait_c;
    logic [15:0] corrupt;
    logic [15:0] exp_err;
    logic        exp_error;
    logic [15:0] exp_bc;
    logic [15:0] exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_bursts;
  logic [15:0] ser;
  logic [15:0] deser;
  logic [31:0] seed;
  logic [3:0]  ready_gap;
  logic        busy, done, error, cfg_err;
  logic [15:0] err_count, burst_count, last_latency;

  int n_vec = 0;
  int n_bad = 0;

  decoupled_vr_if #(.DATA_W(64)) cons_if ();
  decoupled_vr_if #(.DATA_W(64)) prod_if ();

  acc_traffic_driver #(
    .MAX_BURSTS(16'hFFFF),
    .LAT_W     (16),
    .DATA_W    (64)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .num_bursts           (num_bursts),
    .serialization_ratio  (ser),
    .deserialization_ratio(deser),
    .seed                 (seed),
    .ready_gap            (ready_gap),
    .consumer_data        (cons_if),
    .producer_data        (prod_if),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .cfg_err              (cfg_err),
    .err_count            (err_count),
    .burst_count          (burst_count),
    .last_latency         (last_latency)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one configuration to completion with an always-accepting consumer
  // and a producer that echoes the last sent word of each burst.
  task automatic do_run(input vec_t v, input bit hold);
    logic [31:0] exp_word, last_word;
    int sent, sb, rcv, d, cyc, rdy_at;
    bit in_recv, go_recv;
    @(negedge clk);
    seed = v.seed; ser = v.ser; deser = v.deser; num_bursts = v.bursts; ready_gap = v.gap;
    start = 1'b0; cons_if.ready = 1'b0; prod_if.valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    check("run_errcnt_clear", 64'(err_count), 64'd0);
    exp_word = v.seed; last_word = 32'd0;
    sent = 0; sb = 0; rcv = 0; d = 0; cyc = 0; rdy_at = -1; in_recv = 1'b0;
    while (!done && cyc < 2000) begin
      go_recv = 1'b0;
      cons_if.ready = 1'b1;
      if (cons_if.valid) begin
        check("send_word", cons_if.data, {2{exp_word}});
        last_word = exp_word;
        exp_word  = exp_word + 32'd1;
        sent++; sb++;
        if (sb == int'(v.ser)) begin
          sb = 0;
          go_recv = 1'b1;
        end
      end
      if (in_recv) begin
        if (prod_if.ready && rdy_at < 0) rdy_at = d;
        prod_if.valid = (d >= v.wait_c);
        prod_if.data  = {2{last_word}} ^ (((rcv < 16) && v.corrupt[rcv[3:0]]) ? 64'd1 : 64'd0);
        d++;
        if (prod_if.valid && prod_if.ready) begin
          rcv++;
          if (rcv == int'(v.deser)) begin
            check("ready_rise", 64'(rdy_at), 64'(v.gap));
            in_recv = 1'b0; rcv = 0; d = 0; rdy_at = -1;
          end
        end
      end else begin
        prod_if.valid = 1'b0;
      end
      if (go_recv) in_recv = 1'b1;
      cyc++;
      @(negedge clk);
    end
    prod_if.valid = 1'b0;
    cons_if.ready = 1'b0;
    check("run_timeout", 64'(cyc < 2000), 64'd1);
    check("run_done", 64'(done), 64'd1);
    check("run_busy_end", 64'(busy), 64'd0);
    check("run_error", 64'(error), 64'(v.exp_error));
    check("run_cfg_err", 64'(cfg_err), 64'd0);
    check("run_err_count", 64'(err_count), 64'(v.exp_err));
    check("run_burst_count", 64'(burst_count), 64'(v.exp_bc));
    check("run_latency", 64'(last_latency), 64'(v.exp_lat));
    check("run_words_sent", 64'(sent), 64'(v.ser) * 64'(v.bursts));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    bit   saw_valid;
    vecs[0] = '{32'h100,      16'd4, 16'd2, 16'd1, 4'd0, 0, 16'h0000, 16'd0, 1'b0, 16'd1, 16'd0};
    vecs[1] = '{32'h100,      16'd4, 16'd2, 16'd1, 4'd0, 0, 16'h0002, 16'd1, 1'b1, 16'd1, 16'd0};
    vecs[2] = '{32'h200,      16'd1, 16'd1, 16'd3, 4'd3, 5, 16'h0000, 16'd0, 1'b0, 16'd3, 16'd5};
    vecs[3] = '{32'hFFFFFFFE, 16'd3, 16'd3, 16'd2, 4'd1, 2, 16'h0000, 16'd0, 1'b0, 16'd2, 16'd2};
    vecs[4] = '{32'h5000,     16'd2, 16'd1, 16'd2, 4'd0, 0, 16'h0001, 16'd2, 1'b1, 16'd2, 16'd0};

    rst_n = 1'b0; start = 1'b0; num_bursts = 16'd0; ser = 16'd0; deser = 16'd0;
    seed = 32'd0; ready_gap = 4'd0;
    cons_if.ready = 1'b0; prod_if.valid = 1'b0; prod_if.data = 64'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(cons_if.valid), 64'd0);
    check("rst_data", cons_if.data, 64'd0);
    check("rst_ready", 64'(prod_if.ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_counts", {16'd0, err_count, burst_count, last_latency}, 64'd0);

    // Zero serialization ratio is rejected straight into DONE.
    seed = 32'h1; ser = 16'd0; deser = 16'd2; num_bursts = 16'd1; ready_gap = 4'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_done", 64'(done), 64'd1);
    check("cfg_cfg_err", 64'(cfg_err), 64'd1);
    check("cfg_error", 64'(error), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cons_if.valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    check("cfg_no_valid", 64'(saw_valid), 64'd0);

    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i], 1'b0);
    end

    // Asynchronous reset while the consumer stalls mid-SEND.
    @(negedge clk);
    seed = 32'hABC; ser = 16'd4; deser = 16'd1; num_bursts = 16'd1; ready_gap = 4'd0;
    cons_if.ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_valid", 64'(cons_if.valid), 64'd1);
    check("stall_data", cons_if.data, {2{32'hABC}});
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(cons_if.valid), 64'd0);
    check("arst_ready", 64'(prod_if.ready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_counts", {16'd0, err_count, burst_count, last_latency}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(vecs[0], 1'b0);

    // start held high through a run must not retrigger; a fresh edge must.
    do_run(vecs[1], 1'b1);
    repeat (5) @(negedge clk);
    check("hold_done", 64'(done), 64'd1);
    check("hold_busy", 64'(busy), 64'd0);
    check("hold_err_count", 64'(err_count), 64'd1);
    do_run(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
